// File: rtl/vga_render_box_multi.sv
// rtl/vga_render_box_multi.sv - N-box RGB444 overlay renderer with double-buffered config and a 2-cycle pipeline
// Lowest box index wins; shadow config commits to active on frame_start.
module vga_render_box_multi #(
  parameter int          N_BOX   = 4,
  parameter logic [11:0] BG      = 12'h000,
  parameter int          BLINK_W = 5,
  parameter int          IDX_W   = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [10:0]      pix_x_in,
  input  logic [9:0]       pix_y_in,
  input  logic             in_screen,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [10:0]      cfg_x,
  input  logic [10:0]      cfg_w,
  input  logic [9:0]       cfg_y,
  input  logic [9:0]       cfg_h,
  input  logic [11:0]      cfg_rgb,
  input  logic             cfg_en,
  input  logic             cfg_blink,
  output logic [3:0]       VGA_R,
  output logic [3:0]       VGA_G,
  output logic [3:0]       VGA_B,
  output logic             write_out,
  output logic [IDX_W-1:0] hit_idx
);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] w;
    logic [9:0]  y;
    logic [9:0]  h;
    logic [11:0] rgb;
    logic        en;
    logic        blink;
  } box_t;

  box_t               r_shadow [N_BOX];
  box_t               r_active [N_BOX];
  box_t               w_eff    [N_BOX];
  box_t               w_new;
  logic [BLINK_W-1:0] r_frame_cnt;
  logic [BLINK_W-1:0] w_cnt_eff;
  logic               r_ready;
  logic               w_wr;
  logic [N_BOX-1:0]   w_hit;
  logic [N_BOX-1:0]   r_s1_hit;
  logic [11:0]        r_s1_rgb [N_BOX];
  logic               r_s1_scr;
  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic [11:0]        w_win_rgb;
  logic [11:0]        r_rgb;
  logic               r_write;
  logic [IDX_W-1:0]   r_hit_idx;

  assign cfg_ready = r_ready & ~frame_start;
  assign w_wr      = cfg_valid & cfg_ready;
  assign w_new     = '{cfg_x, cfg_w, cfg_y, cfg_h, cfg_rgb, cfg_en, cfg_blink};

  // Indices >= N_BOX match no slot, so such writes are accepted and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i < N_BOX; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_ready <= 1'b1;
      for (int i = 0; i < N_BOX; i++) begin
        if (w_wr && (cfg_idx == IDX_W'(i))) r_shadow[i] <= w_new;
      end
      if (frame_start) begin
        for (int i = 0; i < N_BOX; i++) r_active[i] <= r_shadow[i];
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // A pixel sampled on the commit edge already sees the newly committed boxes.
  always_comb begin
    w_cnt_eff = frame_start ? (r_frame_cnt + 1'b1) : r_frame_cnt;
    for (int i = 0; i < N_BOX; i++) begin
      w_eff[i] = frame_start ? r_shadow[i] : r_active[i];
      w_hit[i] = w_eff[i].en
              && (!w_eff[i].blink || !w_cnt_eff[BLINK_W-1])
              && (pix_x_in >= w_eff[i].x)
              && ({1'b0, pix_x_in} < ({1'b0, w_eff[i].x} + {1'b0, w_eff[i].w}))
              && (pix_y_in >= w_eff[i].y)
              && ({1'b0, pix_y_in} < ({1'b0, w_eff[i].y} + {1'b0, w_eff[i].h}));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hit <= '0;
      r_s1_scr <= 1'b0;
      for (int i = 0; i < N_BOX; i++) r_s1_rgb[i] <= '0;
    end else begin
      r_s1_hit <= w_hit;
      r_s1_scr <= in_screen;
      for (int i = 0; i < N_BOX; i++) r_s1_rgb[i] <= w_eff[i].rgb;
    end
  end

  // Scan from the top so the lowest-index hit is the last assignment.
  always_comb begin
    w_any     = 1'b0;
    w_win     = '0;
    w_win_rgb = BG;
    for (int i = N_BOX - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_any     = 1'b1;
        w_win     = IDX_W'(i);
        w_win_rgb = r_s1_rgb[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb     <= '0;
      r_write   <= 1'b0;
      r_hit_idx <= '0;
    end else if (!r_s1_scr) begin
      r_rgb     <= '0;
      r_write   <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_rgb     <= w_win_rgb;
      r_write   <= w_any;
      r_hit_idx <= w_any ? w_win : '0;
    end
  end

  assign VGA_R     = r_rgb[11:8];
  assign VGA_G     = r_rgb[7:4];
  assign VGA_B     = r_rgb[3:0];
  assign write_out = r_write;
  assign hit_idx   = r_hit_idx;

endmodule

// File: tb/tb_vga_render_box_multi.sv
// tb/tb_vga_render_box_multi.sv - directed-vector bench for vga_render_box_multi
// DUT built with N_BOX=3 (so index 3 is out of range), BLINK_W=2 and a non-zero BG.
module tb_vga_render_box_multi;

  localparam logic [11:0] BG  = 12'h123;
  localparam logic [14:0] BGV = {BG, 3'b000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] pix_x_in = '0;
  logic [9:0]  pix_y_in = '0;
  logic        in_screen = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_idx = '0;
  logic [10:0] cfg_x = '0;
  logic [10:0] cfg_w = '0;
  logic [9:0]  cfg_y = '0;
  logic [9:0]  cfg_h = '0;
  logic [11:0] cfg_rgb = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_blink = 1'b0;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        write_out;
  logic [1:0]  hit_idx;
  logic [14:0] obs;

  int n_vec = 0;
  int n_err = 0;
  int frames = 0;

  vga_render_box_multi #(.N_BOX(3), .BG(BG), .BLINK_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_x_in(pix_x_in), .pix_y_in(pix_y_in), .in_screen(in_screen),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_w(cfg_w), .cfg_y(cfg_y), .cfg_h(cfg_h),
    .cfg_rgb(cfg_rgb), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .write_out(write_out), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  assign obs = {VGA_R, VGA_G, VGA_B, write_out, hit_idx};

  function automatic logic [14:0] hit(input logic [11:0] rgb, input logic [1:0] idx);
    return {rgb, 1'b1, idx};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic scr);
    pix_x_in  = 11'(x);
    pix_y_in  = 10'(y);
    in_screen = scr;
    tick();
    tick();
  endtask

  task automatic do_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    frames++;
  endtask

  task automatic cfg_write(input int idx, input int x, input int w, input int y, input int h,
                           input logic [11:0] rgb, input logic en, input logic blink);
    bit done = 0;
    cfg_idx = 2'(idx); cfg_x = 11'(x); cfg_w = 11'(w); cfg_y = 10'(y); cfg_h = 10'(h);
    cfg_rgb = rgb; cfg_en = en; cfg_blink = blink; cfg_valid = 1'b1;
    #1;
    for (int k = 0; k < 4 && !done; k++) begin
      if (cfg_ready) done = 1;
      tick();
    end
    cfg_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL cfg_write_timeout idx=%0d cfg_ready=%b want 1", idx, cfg_ready);
    end
  endtask

  task automatic test_reset;
    tick(); tick();
    n_vec++;
    if (obs !== 15'h0) begin n_err++; $display("FAIL reset_outputs got %h want 0", obs); end
    n_vec++;
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", cfg_ready); end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got %b want 0", cfg_ready); end
    tick();
    n_vec++;
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge got %b want 1", cfg_ready); end
    frames = 0;
  endtask

  task automatic test_background;
    int xs[3] = '{10, 10, 2047};
    int ys[3] = '{10, 10, 1023};
    logic sc[3] = '{1'b1, 1'b0, 1'b1};
    logic [14:0] ex[3];
    ex = '{BGV, 15'h0, BGV};
    for (int i = 0; i < 3; i++) begin
      pix(xs[i], ys[i], sc[i]);
      n_vec++;
      if (obs !== ex[i]) begin n_err++; $display("FAIL background[%0d] got %h want %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_single_box;
    int xs[6] = '{119, 120, 100, 100, 99, 119};
    int ys[6] = '{59, 59, 60, 50, 50, 59};
    logic sc[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [14:0] ex[6];
    ex = '{hit(12'hF00, 1), BGV, BGV, hit(12'hF00, 1), BGV, 15'h0};
    cfg_write(1, 100, 20, 50, 10, 12'hF00, 1'b1, 1'b0);
    pix(110, 55, 1'b1);
    n_vec++;
    if (obs !== BGV) begin n_err++; $display("FAIL single_precommit got %h want %h", obs, BGV); end
    do_frame();
    for (int i = 0; i < 6; i++) begin
      pix(xs[i], ys[i], sc[i]);
      n_vec++;
      if (obs !== ex[i]) begin n_err++; $display("FAIL single_box[%0d] got %h want %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_overlap;
    cfg_write(2, 5, 10, 5, 10, 12'h00F, 1'b1, 1'b0);
    cfg_write(0, 0, 20, 0, 20, 12'h0F0, 1'b1, 1'b0);
    do_frame();
    pix(10, 10, 1'b1);
    n_vec++;
    if (obs !== hit(12'h0F0, 0)) begin n_err++; $display("FAIL overlap_green got %h want %h", obs, hit(12'h0F0, 0)); end
    pix(17, 17, 1'b1);
    n_vec++;
    if (obs !== hit(12'h0F0, 0)) begin n_err++; $display("FAIL overlap_box0_only got %h want %h", obs, hit(12'h0F0, 0)); end
    cfg_write(0, 0, 20, 0, 20, 12'h0F0, 1'b0, 1'b0);
    pix(10, 10, 1'b1);
    n_vec++;
    if (obs !== hit(12'h0F0, 0)) begin n_err++; $display("FAIL overlap_shadowed got %h want %h", obs, hit(12'h0F0, 0)); end
    do_frame();
    pix(10, 10, 1'b1);
    n_vec++;
    if (obs !== hit(12'h00F, 2)) begin n_err++; $display("FAIL overlap_blue got %h want %h", obs, hit(12'h00F, 2)); end
    pix(2, 2, 1'b1);
    n_vec++;
    if (obs !== BGV) begin n_err++; $display("FAIL overlap_disabled got %h want %h", obs, BGV); end
  endtask

  task automatic test_stall;
    cfg_idx = 2'd0; cfg_x = 11'd300; cfg_w = 11'd10; cfg_y = 10'd300; cfg_h = 10'd10;
    cfg_rgb = 12'hFFF; cfg_en = 1'b1; cfg_blink = 1'b0;
    cfg_valid = 1'b1;
    frame_start = 1'b1;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_low got %b want 0", cfg_ready); end
    tick();
    frame_start = 1'b0;
    frames++;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_high got %b want 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    pix(305, 305, 1'b1);
    n_vec++;
    if (obs !== BGV) begin n_err++; $display("FAIL stall_not_in_commit got %h want %h", obs, BGV); end
    do_frame();
    pix(305, 305, 1'b1);
    n_vec++;
    if (obs !== hit(12'hFFF, 0)) begin n_err++; $display("FAIL stall_committed got %h want %h", obs, hit(12'hFFF, 0)); end
  endtask

  task automatic test_bad_idx;
    int xs[4] = '{505, 305, 115, 10};
    int ys[4] = '{505, 305, 55, 10};
    logic [14:0] ex[4];
    ex = '{BGV, hit(12'hFFF, 0), hit(12'hF00, 1), hit(12'h00F, 2)};
    cfg_write(3, 500, 10, 500, 10, 12'hABC, 1'b1, 1'b0);
    do_frame();
    for (int i = 0; i < 4; i++) begin
      pix(xs[i], ys[i], 1'b1);
      n_vec++;
      if (obs !== ex[i]) begin n_err++; $display("FAIL bad_idx[%0d] got %h want %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_blink;
    logic [14:0] ex;
    cfg_write(2, 5, 10, 5, 10, 12'h00F, 1'b1, 1'b1);
    do_frame();
    for (int i = 0; i < 6; i++) begin
      ex = ((frames % 4) < 2) ? hit(12'h00F, 2) : BGV;
      pix(10, 10, 1'b1);
      n_vec++;
      if (obs !== ex) begin n_err++; $display("FAIL blink cnt=%0d got %h want %h", frames % 4, obs, ex); end
      do_frame();
    end
  endtask

  task automatic test_edge;
    int xs[10] = '{2040, 2047, 2039, 3, 2047, 0, 3, 4, 0, 0};
    int ys[10] = '{0, 9, 0, 0, 10, 1023, 1023, 1023, 1014, 2};
    logic [14:0] ex[10];
    ex = '{hit(12'hF0F, 0), hit(12'hF0F, 0), BGV, BGV, BGV,
           hit(12'h0FF, 1), hit(12'h0FF, 1), BGV, BGV, BGV};
    cfg_write(0, 2040, 20, 0, 10, 12'hF0F, 1'b1, 1'b0);
    cfg_write(1, 0, 4, 1015, 20, 12'h0FF, 1'b1, 1'b0);
    cfg_write(2, 0, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    do_frame();
    for (int i = 0; i < 10; i++) begin
      pix(xs[i], ys[i], 1'b1);
      n_vec++;
      if (obs !== ex[i]) begin n_err++; $display("FAIL edge[%0d] got %h want %h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int xs[5] = '{2045, 10, 2045, 2041, 0};
    int ys[5] = '{5, 10, 5, 3, 0};
    logic sc[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [14:0] ex[5];
    ex = '{hit(12'hF0F, 0), BGV, 15'h0, hit(12'hF0F, 0), 15'h0};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        pix_x_in = 11'(xs[i]); pix_y_in = 10'(ys[i]); in_screen = sc[i];
      end
      tick();
      if (i >= 1) begin
        n_vec++;
        if (obs !== ex[i-1]) begin n_err++; $display("FAIL back_to_back[%0d] got %h want %h", i - 1, obs, ex[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    pix(2045, 5, 1'b1);
    n_vec++;
    if (obs !== hit(12'hF0F, 0)) begin n_err++; $display("FAIL rst_mid_pre got %h want %h", obs, hit(12'hF0F, 0)); end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 15'h0) begin n_err++; $display("FAIL rst_mid_outputs got %h want 0", obs); end
    n_vec++;
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready got %b want 0", cfg_ready); end
    #1;
    rst_n = 1'b1;
    frames = 0;
    tick();
    pix(2045, 5, 1'b1);
    n_vec++;
    if (obs !== BGV) begin n_err++; $display("FAIL rst_mid_active_clear got %h want %h", obs, BGV); end
    do_frame();
    pix(2045, 5, 1'b1);
    n_vec++;
    if (obs !== BGV) begin n_err++; $display("FAIL rst_mid_shadow_clear got %h want %h", obs, BGV); end
  endtask

  task automatic test_zero_size;
    cfg_write(0, 50, 0, 50, 10, 12'hF00, 1'b1, 1'b0);
    cfg_write(1, 50, 10, 50, 0, 12'h0F0, 1'b1, 1'b0);
    cfg_write(2, 50, 10, 50, 10, 12'h00F, 1'b1, 1'b0);
    do_frame();
    pix(55, 55, 1'b1);
    n_vec++;
    if (obs !== hit(12'h00F, 2)) begin n_err++; $display("FAIL zero_size_mid got %h want %h", obs, hit(12'h00F, 2)); end
    pix(50, 50, 1'b1);
    n_vec++;
    if (obs !== hit(12'h00F, 2)) begin n_err++; $display("FAIL zero_size_corner got %h want %h", obs, hit(12'h00F, 2)); end
  endtask

  initial begin
    test_reset();
    test_background();
    test_single_box();
    test_overlap();
    test_stall();
    test_bad_idx();
    test_blink();
    test_edge();
    test_back_to_back();
    test_reset_mid();
    test_zero_size();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
